// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display among NUM_REQ requesters.
// Optional build macro SEG_ARB_PREEMPT_EN makes requester 0 urgent (preempts any other owner).
module seven_segment_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          DWELL_CYCLES = 50_000_000,
  parameter logic [31:0] IDLE_VAL     = 32'h0000_0000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [NUM_REQ-1:0]     req_in,
  input  logic [32*NUM_REQ-1:0]  val_in,
  output logic [31:0]            val_out,
  output logic                   valid_out,
  output logic [NUM_REQ-1:0]     grant_out,
  output logic [2:0]             owner_out,
  output logic                   switch_out
);

  localparam int            CW      = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t               state;
  logic [2:0]           rr_ptr;
  logic [CW-1:0]        dwell_cnt;

  logic [2:0]           pick;
  logic                 pick_found;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [31:0]          pick_val;
  logic [31:0]          owner_val;
  logic [2:0]           rr_next;
  logic                 owner_req;
  logic                 expired;

  // Pick = requester with the smallest rotational distance from rr_ptr,
  // never the current owner while showing.
  always_comb begin
    int best_d;
    int d;
    best_d    = NUM_REQ;
    d         = 0;
    pick      = '0;
    pick_oh   = '0;
    pick_val  = IDLE_VAL;
    owner_val = IDLE_VAL;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = j - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQ;
      if (req_in[j] && !(state == SHOW && owner_out == 3'(j)) && d < best_d) begin
        best_d = d;
        pick   = 3'(j);
      end
    end
    pick_found = (best_d < NUM_REQ);
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick == 3'(j)) begin
        pick_oh[j] = 1'b1;
        pick_val   = val_in[32*j +: 32];
      end
      if (owner_out == 3'(j)) owner_val = val_in[32*j +: 32];
    end
  end

  assign rr_next   = (int'(pick) == NUM_REQ - 1) ? 3'd0 : pick + 3'd1;
  assign owner_req = |(req_in & grant_out);
  assign expired   = (dwell_cnt == CNT_MAX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      dwell_cnt  <= '0;
      val_out    <= IDLE_VAL;
      valid_out  <= 1'b0;
      grant_out  <= '0;
      owner_out  <= '0;
      switch_out <= 1'b0;
    end else begin
      switch_out <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state      <= SHOW;
            valid_out  <= 1'b1;
            grant_out  <= pick_oh;
            owner_out  <= pick;
            switch_out <= 1'b1;
            val_out    <= pick_val;
            dwell_cnt  <= '0;
            rr_ptr     <= rr_next;
          end else begin
            val_out <= IDLE_VAL;
          end
        end
        SHOW: begin
`ifdef SEG_ARB_PREEMPT_EN
          // Preemptive grants leave rr_ptr alone so rotation resumes afterwards.
          if (req_in[0] && owner_out != 3'd0) begin
            grant_out  <= NUM_REQ'(1);
            owner_out  <= 3'd0;
            switch_out <= 1'b1;
            val_out    <= val_in[31:0];
            dwell_cnt  <= '0;
          end else if (req_in[0]) begin
            val_out <= owner_val;
            if (!expired) dwell_cnt <= dwell_cnt + CW'(1);
          end else
`endif
          if (!owner_req || (expired && pick_found)) begin
            if (pick_found) begin
              grant_out  <= pick_oh;
              owner_out  <= pick;
              switch_out <= 1'b1;
              val_out    <= pick_val;
              dwell_cnt  <= '0;
              rr_ptr     <= rr_next;
            end else begin
              state     <= IDLE;
              valid_out <= 1'b0;
              grant_out <= '0;
              owner_out <= '0;
              val_out   <= IDLE_VAL;
              dwell_cnt <= '0;
            end
          end else begin
            val_out <= owner_val;
            if (!expired) dwell_cnt <= dwell_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Self-checking bench for seven_segment_arbiter: directed scenarios plus random
// request/value traffic against a cycle-level ownership model.
module tb_seven_segment_arbiter;
  localparam int          NR    = 4;
  localparam int          DWELL = 4;
  localparam logic [31:0] IDLE  = 32'hDEAD_0000;

  logic                clk;
  logic                rst_n;
  logic [NR-1:0]       req;
  logic [NR-1:0][31:0] vals;
  logic [31:0]         val_out;
  logic                valid_out;
  logic [NR-1:0]       grant_out;
  logic [2:0]          owner_out;
  logic                switch_out;

  seven_segment_arbiter #(.NUM_REQ(NR), .DWELL_CYCLES(DWELL), .IDLE_VAL(IDLE)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .val_in(vals),
    .val_out(val_out), .valid_out(valid_out), .grant_out(grant_out),
    .owner_out(owner_out), .switch_out(switch_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: who owns the display, how many cycles since the grant, where rotation resumes.
  bit          m_valid;
  int          m_owner;
  int          m_held;
  int          m_rr;
  bit          m_sw;
  logic [31:0] m_val;

  bit rec;
  int sw_owners[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [NR-1:0] r, input int start, input int excl);
    for (int d = 0; d < NR; d++) begin
      int k;
      k = (start + d) % NR;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_valid = 0; m_owner = 0; m_held = 0; m_rr = 0; m_sw = 0; m_val = IDLE;
  endtask

  task automatic m_grant(input int p, input bit upd_rr);
    m_valid = 1; m_owner = p; m_sw = 1; m_held = 0; m_val = vals[p];
    if (upd_rr) m_rr = (p + 1) % NR;
  endtask

  task automatic m_next(input logic [NR-1:0] r);
    int p;
    bit done;
    m_sw = 0;
    done = 0;
    if (!m_valid) begin
      p = m_pick(r, m_rr, -1);
      if (p >= 0) m_grant(p, 1);
      else m_val = IDLE;
    end else begin
`ifdef SEG_ARB_PREEMPT_EN
      if (r[0] && m_owner != 0) begin
        m_grant(0, 0);
        done = 1;
      end else if (r[0]) begin
        m_held++;
        m_val = vals[m_owner];
        done = 1;
      end
`endif
      if (!done) begin
        p = m_pick(r, m_rr, m_owner);
        if (!r[m_owner]) begin
          if (p >= 0) m_grant(p, 1);
          else begin m_valid = 0; m_owner = 0; m_val = IDLE; end
        end else if (m_held >= DWELL - 1 && p >= 0) begin
          m_grant(p, 1);
        end else begin
          m_held++;
          m_val = vals[m_owner];
        end
      end
    end
  endtask

  task automatic compare();
    chk("val", val_out, m_val);
    chk("valid", 32'(valid_out), 32'(m_valid));
    chk("grant", 32'(grant_out), m_valid ? (32'd1 << m_owner) : 32'd0);
    chk("owner", 32'(owner_out), 32'(m_owner));
    chk("switch", 32'(switch_out), 32'(m_sw));
    if (rec && switch_out) sw_owners.push_back(int'(owner_out));
  endtask

  // Called at a falling edge: drive, advance model across the next rising edge, compare.
  task automatic step(input logic [NR-1:0] r);
    req = r;
    m_next(r);
    @(negedge clk);
    compare();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_val"}, val_out, IDLE);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_grant"}, 32'(grant_out), 32'd0);
    chk({tag, "_owner"}, 32'(owner_out), 32'd0);
    chk({tag, "_switch"}, 32'(switch_out), 32'd0);
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    logic [NR-1:0] r;
    rst_n = 1'b0;
    req   = '0;
    vals  = '0;
    rec   = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("rst_init");

    // Single requester: grant, live value tracking, no further switches.
    vals[1] = 32'h1234_5678;
    step(4'b0010);
    vals[1] = 32'hAAAA_5555;
    repeat (20) step(4'b0010);

    // Reset while showing.
    async_reset();
    step(4'b0000);

    // Contention from IDLE with rr_ptr=0.
    vals[0] = 32'h0000_0A0A; vals[1] = 32'h0000_1B1B; vals[3] = 32'h0000_3D3D;
    rec = 1;
    repeat (15) step(4'b1011);
    rec = 0;
    chk("order_len", 32'(sw_owners.size()), 32'd4);
    if (sw_owners.size() >= 4) begin
      chk("order_0", 32'(sw_owners[0]), 32'd0);
      chk("order_1", 32'(sw_owners[1]), 32'd1);
      chk("order_2", 32'(sw_owners[2]), 32'd3);
      chk("order_3", 32'(sw_owners[3]), 32'd0);
    end

    // Early release by owner 1 with requester 3 waiting, then everything drops.
    async_reset();
    repeat (3) step(4'b1010);
    step(4'b1000);
    chk("early_grant", 32'(grant_out), 32'h8);
    step(4'b0000);
    chk("drop_valid", 32'(valid_out), 32'd0);
    step(4'b0000);

    // Saturated dwell, then a late contender.
    vals[2] = 32'h2222_2222;
    repeat (11) step(4'b0100);
    step(4'b0101);
    chk("sat_grant", 32'(grant_out), 32'h1);
    step(4'b0101);

    // Random traffic.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 3) == 0) vals[$urandom_range(0, NR-1)] = $urandom;
      if ($urandom_range(0, 399) == 0) async_reset();
      step(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
